// File: rtl/serial_add_pkg.sv
// Shared types and sizes for the bit-serial add scheduler.
package serial_add_pkg;

    localparam int OP_W  = 8;
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Identifies which requester owns (or last owned) the adder.
    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_idx_t;

endpackage

// File: rtl/add_bit_cell.sv
// One-bit full adder built from two half-adder stages and an OR of their carries.
module add_bit_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic hs1_sum;
    logic hs1_carry;
    logic hs2_carry;

    // First half adder combines the operand bits, second folds in the carry.
    always_comb begin
        hs1_sum   = a ^ b;
        hs1_carry = a & b;
        s         = hs1_sum ^ cin;
        hs2_carry = hs1_sum & cin;
        cout      = hs1_carry | hs2_carry;
    end

endmodule

// File: rtl/serial_add_sched.sv
// Round-robin scheduler sharing one LSB-first bit-serial adder between two requesters.
module serial_add_sched
    import serial_add_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic [7:0] op_a_x,
    input  logic [7:0] op_a_y,
    input  logic       req_b,
    input  logic [7:0] op_b_x,
    input  logic [7:0] op_b_y,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       done_a,
    output logic       done_b,
    output logic [8:0] sum,
    output logic       busy
);

    state_t            state_q, state_d;
    req_idx_t          last_q, last_d;    // owner of the current op, and the last grant
    logic [OP_W-1:0]   x_q, x_d;
    logic [OP_W-1:0]   y_q, y_d;
    logic [OP_W-1:0]   res_q, res_d;      // sum bits enter at the MSB and shift down
    logic              carry_q, carry_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OP_W:0]     sum_q, sum_d;

    logic              bit_s;
    logic              bit_c;

    add_bit_cell u_bit (
        .a    (x_q[0]),
        .b    (y_q[0]),
        .cin  (carry_q),
        .s    (bit_s),
        .cout (bit_c)
    );

    // State, arbitration flag, datapath shift registers and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= REQ_B;
            x_q     <= '0;
            y_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            x_q     <= x_d;
            y_q     <= y_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
        end
    end

    // Next-state, round-robin grant and serial add step.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        x_d     = x_q;
        y_d     = y_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;

        case (state_q)
            IDLE: begin
                if (req_a || req_b) begin
                    state_d = LOAD;
                    if (req_a && req_b) begin
                        last_d = (last_q == REQ_B) ? REQ_A : REQ_B;
                    end else begin
                        last_d = req_a ? REQ_A : REQ_B;
                    end
                end
            end
            LOAD: begin
                x_d     = (last_q == REQ_A) ? op_a_x : op_b_x;
                y_d     = (last_q == REQ_A) ? op_a_y : op_b_y;
                res_d   = '0;
                carry_d = 1'b0;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                x_d     = x_q >> 1;
                y_d     = y_q >> 1;
                res_d   = {bit_s, res_q[OP_W-1:1]};
                carry_d = bit_c;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == '1) begin
                    // Final bit: publish the full result as we enter DONE.
                    sum_d   = {bit_c, bit_s, res_q[OP_W-1:1]};
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Grants and done pulses decode from state so reset clears them at once.
    always_comb begin
        busy   = (state_q != IDLE);
        gnt_a  = busy && (last_q == REQ_A);
        gnt_b  = busy && (last_q == REQ_B);
        done_a = (state_q == DONE) && (last_q == REQ_A);
        done_b = (state_q == DONE) && (last_q == REQ_B);
        sum    = sum_q;
    end

endmodule

// File: tb/tb_serial_add_sched.sv
// Directed bench for serial_add_sched: single requesters, contention, operand/req
// changes mid-operation and reset abort.
module tb_serial_add_sched;
    import serial_add_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_a = 1'b0;
    logic [7:0] op_a_x = '0;
    logic [7:0] op_a_y = '0;
    logic       req_b = 1'b0;
    logic [7:0] op_b_x = '0;
    logic [7:0] op_b_y = '0;
    logic       gnt_a, gnt_b, done_a, done_b, busy;
    logic [8:0] sum;

    int checks = 0;
    int errors = 0;

    localparam int MAXC = 40;
    logic       log_da [MAXC];
    logic       log_db [MAXC];
    logic       log_ga [MAXC];
    logic       log_gb [MAXC];
    logic [8:0] log_sum[MAXC];
    int         log_n;

    serial_add_sched dut (
        .clk    (clk),
        .rst    (rst),
        .req_a  (req_a),
        .op_a_x (op_a_x),
        .op_a_y (op_a_y),
        .req_b  (req_b),
        .op_b_x (op_b_x),
        .op_b_y (op_b_y),
        .gnt_a  (gnt_a),
        .gnt_b  (gnt_b),
        .done_a (done_a),
        .done_b (done_b),
        .sum    (sum),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance n cycles from cycle 0, logging outputs at cycle c (1 ns after its opening edge).
    // drop_c: release both reqs; chg_c: change A operands to FF and drop req_a.
    task automatic run_cycles(input int n, input int drop_c, input int chg_c);
        for (int i = 0; i < MAXC; i++) begin
            log_da[i] = 1'b0; log_db[i] = 1'b0; log_ga[i] = 1'b0; log_gb[i] = 1'b0;
            log_sum[i] = '0;
        end
        log_n = n;
        for (int c = 1; c <= n; c++) begin
            @(posedge clk); #1;
            if (c == drop_c) begin req_a = 1'b0; req_b = 1'b0; end
            if (c == chg_c) begin op_a_x = 8'hFF; op_a_y = 8'hFF; req_a = 1'b0; end
            log_da[c] = done_a; log_db[c] = done_b;
            log_ga[c] = gnt_a;  log_gb[c] = gnt_b;
            log_sum[c] = sum;
        end
    endtask

    // sel: 0 done_a, 1 done_b, 2 gnt_a, 3 gnt_b. Returns first cycle >= from, or 99.
    function automatic int first_hit(input int sel, input int from);
        for (int c = from; c <= log_n; c++) begin
            if ((sel == 0 && log_da[c]) || (sel == 1 && log_db[c]) ||
                (sel == 2 && log_ga[c]) || (sel == 3 && log_gb[c]))
                return c;
        end
        return 99;
    endfunction

    function automatic int count_hits(input int sel);
        int n = 0;
        for (int c = 1; c <= log_n; c++) begin
            if ((sel == 0 && log_da[c]) || (sel == 1 && log_db[c]) ||
                (sel == 2 && log_ga[c]) || (sel == 3 && log_gb[c]))
                n++;
        end
        return n;
    endfunction

    function automatic logic [8:0] sum_at(input int c);
        if (c >= 1 && c <= log_n) return log_sum[c];
        return 9'h1AA;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Protocol properties held throughout
    logic prev_da = 1'b0;
    logic prev_db = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            assert (!(gnt_a && gnt_b)) else $error("grant overlap");
            assert (!(done_a && prev_da)) else $error("done_a wider than one cycle");
            assert (!(done_b && prev_db)) else $error("done_b wider than one cycle");
            assert (busy == (dut.state_q != IDLE)) else $error("busy disagrees with state");
        end
        prev_da <= done_a;
        prev_db <= done_b;
    end

    initial begin
        do_reset();
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_gnt", 16'({gnt_a, gnt_b}), 16'h0);
        chk("rst_sum", 16'(sum), 16'h0);

        // A alone: 5A + 3C
        op_a_x = 8'h5A; op_a_y = 8'h3C; req_a = 1'b1;
        run_cycles(14, 1, 0);
        chk("a1_gnt_c1", 16'(log_ga[1]), 16'h1);
        chk("a1_done_cyc", 16'(first_hit(0, 1)), 16'd10);
        chk("a1_sum", 16'(sum_at(10)), 16'h096);
        chk("a1_sum_hold", 16'(sum_at(14)), 16'h096);
        chk("a1_no_gnt_b", 16'(count_hits(3)), 16'd0);
        chk("a1_no_done_b", 16'(count_hits(1)), 16'd0);
        chk("a1_done_cnt", 16'(count_hits(0)), 16'd1);

        // A alone: FF + 01
        op_a_x = 8'hFF; op_a_y = 8'h01; req_a = 1'b1;
        run_cycles(14, 1, 0);
        chk("a2_done_cyc", 16'(first_hit(0, 1)), 16'd10);
        chk("a2_sum", 16'(sum_at(10)), 16'h100);

        // B alone: FF + FF
        op_b_x = 8'hFF; op_b_y = 8'hFF; req_b = 1'b1;
        run_cycles(14, 1, 0);
        chk("b1_done_cyc", 16'(first_hit(1, 1)), 16'd10);
        chk("b1_sum", 16'(sum_at(10)), 16'h1FE);
        chk("b1_no_gnt_a", 16'(count_hits(2)), 16'd0);

        // Both held from reset: A wins first, then B
        do_reset();
        op_a_x = 8'h10; op_a_y = 8'h20; op_b_x = 8'h03; op_b_y = 8'h04;
        req_a = 1'b1; req_b = 1'b1;
        run_cycles(24, 22, 0);
        chk("ab_done_a_cyc", 16'(first_hit(0, 1)), 16'd10);
        chk("ab_sum_a", 16'(sum_at(10)), 16'h030);
        chk("ab_gnt_b_cyc", 16'(first_hit(3, 1)), 16'd12);
        chk("ab_gnt_a_c12", 16'(log_ga[12]), 16'h0);
        chk("ab_done_b_cyc", 16'(first_hit(1, 1)), 16'd21);
        chk("ab_sum_b", 16'(sum_at(21)), 16'h007);
        chk("ab_sum_b_hold", 16'(sum_at(24)), 16'h007);

        // Operands change and req drops after LOAD
        op_a_x = 8'h01; op_a_y = 8'h01; req_a = 1'b1;
        run_cycles(14, 0, 4);
        chk("chg_done_cyc", 16'(first_hit(0, 1)), 16'd10);
        chk("chg_sum", 16'(sum_at(10)), 16'h002);

        // Reset mid-operation
        op_a_x = 8'h5A; op_a_y = 8'h3C; req_a = 1'b1;
        run_cycles(5, 1, 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 16'(busy), 16'h0);
        chk("mid_rst_gnt", 16'({gnt_a, gnt_b}), 16'h0);
        chk("mid_rst_done", 16'({done_a, done_b}), 16'h0);
        chk("mid_rst_sum", 16'(sum), 16'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        op_b_x = 8'h12; op_b_y = 8'h34; req_b = 1'b1;
        run_cycles(14, 1, 0);
        chk("post_rst_done_b", 16'(first_hit(1, 1)), 16'd10);
        chk("post_rst_sum", 16'(sum_at(10)), 16'h046);
        chk("post_rst_no_done_a", 16'(count_hits(0)), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit in case the bench itself stalls.
    initial begin
        #20000;
        $display("FAIL timeout got=stalled exp=finish");
        $fatal(1, "time limit");
    end

endmodule
